// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg: shared state type and limits for the SPI frame arbiter
package spi_ctrl_pkg;
   localparam int MaxNumReq = 4;
   typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_XFER, ST_DRAIN, ST_GAP} spi_arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, search starts after the last winner
module rr_arbiter
   import spi_ctrl_pkg::*;
#(
   parameter int N = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] req_i,
   input  logic         adv_i,
   output logic [N-1:0] grant_o
);
   localparam int PW = $clog2(MaxNumReq);
   logic [PW-1:0] r_ptr, w_nxt_ptr;
   logic [N-1:0]  w_rot, w_oh;
   // rotate so the pointer sits at bit 0, take lowest set bit, rotate back
   assign w_rot   = N'({req_i, req_i} >> r_ptr);
   assign w_oh    = w_rot & (~w_rot + N'(1));
   assign grant_o = N'(({w_oh, w_oh} << r_ptr) >> N);
   always_comb begin
      w_nxt_ptr = r_ptr;
      for (int i = 0; i < N; i++)
         if (grant_o[i]) w_nxt_ptr = (i == N - 1) ? '0 : PW'(i + 1);
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) r_ptr <= '0;
      else if (adv_i && |req_i) r_ptr <= w_nxt_ptr;
   end
endmodule

// File: rtl/spi_frame_arbiter.sv
// spi_frame_arbiter: multiplexes byte-stream frames from several requesters onto one SPI master
module spi_frame_arbiter
   import spi_ctrl_pkg::*;
#(
   parameter int NumReq      = 2,
   parameter int CsGapCycles = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NumReq-1:0]      req_valid_i,
   input  logic [NumReq-1:0][7:0] req_data_i,
   input  logic [NumReq-1:0]      req_last_i,
   output logic [NumReq-1:0]      req_ready_o,
   output logic                   spi_start_o,
   output logic [7:0]             spi_data_o,
   input  logic                   spi_next_i,
   output logic [NumReq-1:0]      grant_o,
   output logic                   busy_o,
   output logic                   underrun_o
);
   spi_arb_state_e    r_state;
   logic [NumReq-1:0] r_grant, w_arb_grant;
   logic [7:0]        r_cur, r_nxt, w_data;
   logic              r_start, r_cur_last, r_nxt_vld, r_nxt_last, r_last_acc, r_underrun;
   logic [3:0]        r_gap_cnt;
   logic              w_ready, w_vld, w_last, w_acc;

   rr_arbiter #(.N(NumReq)) u_rr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (req_valid_i),
      .adv_i   (r_state == ST_IDLE),
      .grant_o (w_arb_grant)
   );

   always_comb begin
      w_data = '0;
      for (int i = 0; i < NumReq; i++) w_data = w_data | (r_grant[i] ? req_data_i[i] : 8'h00);
   end
   assign w_vld   = |(req_valid_i & r_grant);
   assign w_last  = |(req_last_i & r_grant);
   assign w_ready = (r_state == ST_LOAD) || (r_state == ST_DRAIN) ||
                    (r_state == ST_XFER && !r_nxt_vld && !r_last_acc);
   assign w_acc   = w_vld && w_ready;

   assign req_ready_o = w_ready ? r_grant : '0;
   assign spi_start_o = r_start;
   assign spi_data_o  = r_cur;
   assign grant_o     = r_grant;
   assign busy_o      = (r_state != ST_IDLE);
   assign underrun_o  = r_underrun;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_start    <= 1'b0;
         r_cur      <= 8'h00;
         r_cur_last <= 1'b0;
         r_nxt      <= 8'h00;
         r_nxt_vld  <= 1'b0;
         r_nxt_last <= 1'b0;
         r_last_acc <= 1'b0;
         r_grant    <= '0;
         r_underrun <= 1'b0;
         r_gap_cnt  <= '0;
      end else begin
         r_underrun <= 1'b0;
         case (r_state)
            ST_IDLE:
               if (|req_valid_i) begin
                  r_grant <= w_arb_grant;
                  r_state <= ST_LOAD;
               end
            ST_LOAD:
               if (w_acc) begin
                  r_cur      <= w_data;
                  r_cur_last <= w_last;
                  r_last_acc <= w_last;
                  r_nxt_vld  <= 1'b0;
                  r_start    <= 1'b1;
                  r_state    <= ST_XFER;
               end
            ST_XFER:
               if (spi_next_i) begin
                  if (r_cur_last) begin
                     r_start   <= 1'b0;
                     r_gap_cnt <= 4'(CsGapCycles - 1);
                     r_state   <= ST_GAP;
                  end else if (r_nxt_vld) begin
                     r_cur      <= r_nxt;
                     r_cur_last <= r_nxt_last;
                     r_nxt_vld  <= 1'b0;
                  end else if (w_acc) begin
                     // byte arriving with the pulse goes straight to the shifter
                     r_cur      <= w_data;
                     r_cur_last <= w_last;
                     r_last_acc <= w_last;
                  end else begin
                     r_start    <= 1'b0;
                     r_underrun <= 1'b1;
                     r_state    <= ST_DRAIN;
                  end
               end else if (w_acc) begin
                  r_nxt      <= w_data;
                  r_nxt_last <= w_last;
                  r_nxt_vld  <= 1'b1;
                  r_last_acc <= w_last;
               end
            ST_DRAIN:
               if (w_acc && w_last) begin
                  r_gap_cnt <= 4'(CsGapCycles - 1);
                  r_state   <= ST_GAP;
               end
            ST_GAP:
               if (r_gap_cnt == 4'd0) begin
                  r_grant <= '0;
                  r_state <= ST_IDLE;
               end else r_gap_cnt <= r_gap_cnt - 4'd1;
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_frame_arbiter.sv
// tb_spi_frame_arbiter: directed scenario tests for spi_frame_arbiter
module tb_spi_frame_arbiter;
   logic            clk, rst, nxt, start, busy, underrun;
   logic [1:0]      valid, last, ready, grant;
   logic [1:0][7:0] data;
   logic [7:0]      sdata;
   int              vecs = 0, errs = 0;

   spi_frame_arbiter #(.NumReq(2), .CsGapCycles(4)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (valid),
      .req_data_i  (data),
      .req_last_i  (last),
      .req_ready_o (ready),
      .spi_start_o (start),
      .spi_data_o  (sdata),
      .spi_next_i  (nxt),
      .grant_o     (grant),
      .busy_o      (busy),
      .underrun_o  (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick;
      tick;
      vecs++; if (start !== 1'b0) begin errs++; $display("FAIL reset_start: got %b want 0", start); end
      vecs++; if (sdata !== 8'h00) begin errs++; $display("FAIL reset_data: got %h want 00", sdata); end
      vecs++; if (grant !== 2'b00) begin errs++; $display("FAIL reset_grant: got %b want 00", grant); end
      vecs++; if (ready !== 2'b00) begin errs++; $display("FAIL reset_ready: got %b want 00", ready); end
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
      vecs++; if (underrun !== 1'b0) begin errs++; $display("FAIL reset_underrun: got %b want 0", underrun); end
      rst = 1'b0;
      tick;
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_frame;
      int n;
      logic hi;
      valid = 2'b01; data[0] = 8'hA5; last = 2'b00;
      tick;
      vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL frame_grant: got %b want 01", grant); end
      vecs++; if (ready !== 2'b01) begin errs++; $display("FAIL frame_load_ready: got %b want 01", ready); end
      vecs++; if (start !== 1'b0) begin errs++; $display("FAIL frame_load_start: got %b want 0", start); end
      tick;
      vecs++; if (start !== 1'b1) begin errs++; $display("FAIL frame_start: got %b want 1", start); end
      vecs++; if (sdata !== 8'hA5) begin errs++; $display("FAIL frame_byte0: got %h want a5", sdata); end
      data[0] = 8'h3C; last = 2'b01;
      tick;
      valid = 2'b00; last = 2'b00;
      vecs++; if (ready !== 2'b00) begin errs++; $display("FAIL frame_full_ready: got %b want 00", ready); end
      hi = 1'b1;
      repeat (37) begin tick; hi = hi & start; end
      nxt = 1'b1; tick; nxt = 1'b0;
      vecs++; if (sdata !== 8'h3C) begin errs++; $display("FAIL frame_byte1: got %h want 3c", sdata); end
      hi = hi & start;
      repeat (39) begin tick; hi = hi & start; end
      vecs++; if (hi !== 1'b1) begin errs++; $display("FAIL frame_start_held: got %b want 1", hi); end
      nxt = 1'b1; tick; nxt = 1'b0;
      vecs++; if (start !== 1'b0) begin errs++; $display("FAIL frame_end_start: got %b want 0", start); end
      vecs++; if (underrun !== 1'b0) begin errs++; $display("FAIL frame_underrun: got %b want 0", underrun); end
      n = 0;
      while (busy && n < 20) begin tick; n++; end
      vecs++; if (n !== 4) begin errs++; $display("FAIL frame_gap_len: got %0d want 4", n); end
      vecs++; if (grant !== 2'b00) begin errs++; $display("FAIL frame_idle_grant: got %b want 00", grant); end
   endtask

   task automatic test_alternate;
      int n;
      rst = 1'b1; tick; rst = 1'b0;
      valid = 2'b11; data[0] = 8'h11; data[1] = 8'h22; last = 2'b11;
      tick;
      vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL alt_first_grant: got %b want 01", grant); end
      vecs++; if (ready !== 2'b01) begin errs++; $display("FAIL alt_first_ready: got %b want 01", ready); end
      tick;
      valid = 2'b10;
      vecs++; if (sdata !== 8'h11) begin errs++; $display("FAIL alt_first_data: got %h want 11", sdata); end
      vecs++; if (ready !== 2'b00) begin errs++; $display("FAIL alt_nonowner_ready: got %b want 00", ready); end
      nxt = 1'b1; tick; nxt = 1'b0;
      n = 0;
      while (busy && n < 20) begin tick; n++; end
      vecs++; if (n !== 4) begin errs++; $display("FAIL alt_gap_len: got %0d want 4", n); end
      tick;
      vecs++; if (grant !== 2'b10) begin errs++; $display("FAIL alt_second_grant: got %b want 10", grant); end
      tick;
      vecs++; if (sdata !== 8'h22) begin errs++; $display("FAIL alt_second_data: got %h want 22", sdata); end
      valid = 2'b11; data[0] = 8'h33; data[1] = 8'h44;
      nxt = 1'b1; tick; nxt = 1'b0;
      n = 0;
      while (busy && n < 20) begin tick; n++; end
      tick;
      vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL alt_third_grant: got %b want 01", grant); end
      valid = 2'b00; last = 2'b00;
   endtask

   task automatic test_underrun;
      int n;
      rst = 1'b1; tick; rst = 1'b0;
      valid = 2'b10; data[1] = 8'h10; last = 2'b00;
      tick;
      tick;
      valid = 2'b00;
      vecs++; if (ready !== 2'b10) begin errs++; $display("FAIL urun_xfer_ready: got %b want 10", ready); end
      nxt = 1'b1; tick; nxt = 1'b0;
      vecs++; if (underrun !== 1'b1) begin errs++; $display("FAIL urun_pulse: got %b want 1", underrun); end
      vecs++; if (start !== 1'b0) begin errs++; $display("FAIL urun_start: got %b want 0", start); end
      valid = 2'b10; data[1] = 8'h20;
      vecs++; if (ready !== 2'b10) begin errs++; $display("FAIL urun_drain_ready: got %b want 10", ready); end
      tick;
      vecs++; if (underrun !== 1'b0) begin errs++; $display("FAIL urun_single_pulse: got %b want 0", underrun); end
      vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL urun_drain_busy: got %b want 1", busy); end
      data[1] = 8'h30; last = 2'b10; nxt = 1'b1;
      tick;
      nxt = 1'b0; valid = 2'b00; last = 2'b00;
      vecs++; if (sdata !== 8'h10) begin errs++; $display("FAIL urun_discard: got %h want 10", sdata); end
      vecs++; if (start !== 1'b0) begin errs++; $display("FAIL urun_drain_start: got %b want 0", start); end
      n = 0;
      while (busy && n < 20) begin tick; n++; end
      vecs++; if (n !== 4) begin errs++; $display("FAIL urun_gap_len: got %0d want 4", n); end
   endtask

   task automatic test_bypass;
      int n;
      valid = 2'b01; data[0] = 8'h5A; last = 2'b00;
      tick;
      vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL byp_grant: got %b want 01", grant); end
      tick;
      valid = 2'b00;
      tick;
      tick;
      valid = 2'b01; data[0] = 8'hC3; last = 2'b01; nxt = 1'b1;
      tick;
      valid = 2'b00; last = 2'b00; nxt = 1'b0;
      vecs++; if (underrun !== 1'b0) begin errs++; $display("FAIL byp_underrun: got %b want 0", underrun); end
      vecs++; if (sdata !== 8'hC3) begin errs++; $display("FAIL byp_data: got %h want c3", sdata); end
      vecs++; if (start !== 1'b1) begin errs++; $display("FAIL byp_start: got %b want 1", start); end
      vecs++; if (ready !== 2'b00) begin errs++; $display("FAIL byp_ready: got %b want 00", ready); end
      nxt = 1'b1; tick; nxt = 1'b0;
      vecs++; if (start !== 1'b0) begin errs++; $display("FAIL byp_end_start: got %b want 0", start); end
      n = 0;
      while (busy && n < 20) begin tick; n++; end
      vecs++; if (n !== 4) begin errs++; $display("FAIL byp_gap_len: got %0d want 4", n); end
   endtask

   task automatic test_single;
      int n;
      logic hi;
      valid = 2'b10; data[1] = 8'hFF; last = 2'b10;
      tick;
      vecs++; if (grant !== 2'b10) begin errs++; $display("FAIL single_grant: got %b want 10", grant); end
      tick;
      vecs++; if (sdata !== 8'hFF) begin errs++; $display("FAIL single_data: got %h want ff", sdata); end
      valid = 2'b01; data[0] = 8'h01; last = 2'b01;
      hi = start;
      repeat (3) begin tick; hi = hi & start; end
      vecs++; if (hi !== 1'b1) begin errs++; $display("FAIL single_start_held: got %b want 1", hi); end
      nxt = 1'b1; tick; nxt = 1'b0;
      vecs++; if (start !== 1'b0) begin errs++; $display("FAIL single_end_start: got %b want 0", start); end
      n = 0;
      while (!start && n < 30) begin tick; n++; end
      vecs++; if (n !== 6) begin errs++; $display("FAIL single_cs_low: got %0d want 6", n); end
      vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL single_next_grant: got %b want 01", grant); end
      vecs++; if (sdata !== 8'h01) begin errs++; $display("FAIL single_next_data: got %h want 01", sdata); end
      valid = 2'b00; last = 2'b00;
      nxt = 1'b1; tick; nxt = 1'b0;
      n = 0;
      while (busy && n < 20) begin tick; n++; end
      vecs++; if (n !== 4) begin errs++; $display("FAIL single_gap_len: got %0d want 4", n); end
   endtask

   task automatic test_reset_mid;
      int n;
      valid = 2'b01; data[0] = 8'hAA; last = 2'b00;
      tick;
      tick;
      data[0] = 8'hBB;
      tick;
      rst = 1'b1; valid = 2'b00;
      tick;
      vecs++; if (start !== 1'b0) begin errs++; $display("FAIL rmid_start: got %b want 0", start); end
      vecs++; if (sdata !== 8'h00) begin errs++; $display("FAIL rmid_data: got %h want 00", sdata); end
      vecs++; if (grant !== 2'b00) begin errs++; $display("FAIL rmid_grant: got %b want 00", grant); end
      vecs++; if (ready !== 2'b00) begin errs++; $display("FAIL rmid_ready: got %b want 00", ready); end
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rmid_busy: got %b want 0", busy); end
      vecs++; if (underrun !== 1'b0) begin errs++; $display("FAIL rmid_underrun: got %b want 0", underrun); end
      rst = 1'b0;
      valid = 2'b10; data[1] = 8'h77; last = 2'b10;
      tick;
      vecs++; if (grant !== 2'b10) begin errs++; $display("FAIL rmid_new_grant: got %b want 10", grant); end
      tick;
      valid = 2'b00; last = 2'b00;
      vecs++; if (start !== 1'b1) begin errs++; $display("FAIL rmid_new_start: got %b want 1", start); end
      vecs++; if (sdata !== 8'h77) begin errs++; $display("FAIL rmid_new_data: got %h want 77", sdata); end
      nxt = 1'b1; tick; nxt = 1'b0;
      vecs++; if (start !== 1'b0) begin errs++; $display("FAIL rmid_new_end: got %b want 0", start); end
      vecs++; if (underrun !== 1'b0) begin errs++; $display("FAIL rmid_new_underrun: got %b want 0", underrun); end
      n = 0;
      while (busy && n < 20) begin tick; n++; end
      vecs++; if (n !== 4) begin errs++; $display("FAIL rmid_gap_len: got %0d want 4", n); end
   endtask

   initial begin
      rst = 1'b1; nxt = 1'b0; valid = 2'b00; last = 2'b00; data = '0;
      test_reset;
      test_frame;
      test_alternate;
      test_underrun;
      test_bypass;
      test_single;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/spi_frame_arbiter.md
SPI_FRAME_ARBITER -- requirements
Module: spi_frame_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of byte-stream requesters (2..4).
REQ-002 SHALL have parameter CsGapCycles, default 4, minimum clk_i cycles with spi_start_o low between frames (1..15).
REQ-003 SHALL have port clk_i, input, 1: single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid_i, input, NumReq: requester n has a byte on req_data_i[n].
REQ-006 SHALL have port req_data_i, input, NumReq x 8: byte per requester.
REQ-007 SHALL have port req_last_i, input, NumReq: byte is last of its frame.
REQ-008 SHALL have port req_ready_o, output, NumReq: byte accepted when valid and ready are both high.
REQ-009 SHALL have port spi_start_o, output, 1: registered; drives SPI master start (chip select = not start).
REQ-010 SHALL have port spi_data_o, output, 8: registered byte presented to the SPI master.
REQ-011 SHALL have port spi_next_i, input, 1: one-cycle pulse from the SPI master at the end of each transmitted byte.
REQ-012 SHALL have port grant_o, output, NumReq: one-hot owner of the current frame; zero when idle.
REQ-013 SHALL have port busy_o, output, 1: high in any state except IDLE.
REQ-014 SHALL have port underrun_o, output, 1: one-cycle pulse when a frame aborts on underrun.

Function
REQ-015 SHALL implement states IDLE, LOAD, XFER, DRAIN and GAP.
REQ-016 IDLE: when any req_valid_i is high, SHALL grant round-robin, starting from the index after the last granted requester, and go to LOAD.
REQ-017 LOAD: SHALL accept the first byte into cur_q, and SHALL flag last if req_last_i is high.
REQ-018 LOAD: SHALL set spi_start_o the same edge and go to XFER; LOAD lasts exactly 1 cycle after valid.
REQ-019 XFER: SHALL hold a one-byte prefetch register nxt_q; ready SHALL be high to the owner while nxt_q is empty and the last byte has not been accepted.
REQ-020 XFER, spi_next_i with current byte not last and nxt_q full: SHALL load cur_q from nxt_q and clear nxt_q on the same edge, so new data is stable in the cycle after the pulse.
REQ-021 XFER, spi_next_i with current byte last: SHALL clear spi_start_o on the same edge and go to GAP.
REQ-022 XFER, spi_next_i with current byte not last and nxt_q empty: SHALL clear spi_start_o, pulse underrun_o and go to DRAIN.
REQ-023 A byte arriving on the same edge as spi_next_i SHALL count as present (bypass into cur_q); this is not an underrun.
REQ-024 DRAIN: SHALL hold ready high to the owner and discard bytes up to and including the one with last set, then go to GAP.
REQ-025 GAP: SHALL count CsGapCycles cycles with spi_start_o low, then clear grant_o and return to IDLE.
REQ-026 Non-owner requesters SHALL see ready low at all times.
REQ-027 spi_next_i outside XFER SHALL be ignored.
REQ-028 A single-byte frame (last set in LOAD) SHALL end at the first spi_next_i.

Reset
REQ-029 On rst_i, SHALL set: state IDLE; spi_start_o 0; spi_data_o 0x00; grant_o 0; req_ready_o 0; busy_o 0; underrun_o 0; nxt_q empty; round-robin pointer to requester 0.
REQ-030 Reset asserted mid-frame SHALL drop spi_start_o on the next edge, with no underrun pulse.

Structure
REQ-031 Package spi_ctrl_pkg SHALL hold the state enum type spi_arb_state_e and the maximum NumReq constant.
REQ-032 A sub-module rr_arbiter (request vector, advance strobe, one-hot grant, pointer register) SHALL implement REQ-016.
REQ-033 Target size: 150-300 lines of RTL.

Verification
REQ-034 Req0 sends frame 0xA5,0x3C (last); model spi_next_i every 40 cycles -> spi_data_o shows 0xA5 then 0x3C; spi_start_o is high continuously for 2 bytes and drops on the edge of the 2nd pulse.
REQ-035 Req0 and req1 valid in the same cycle after reset -> grant 0 first; after GAP, grant 1; a second simultaneous request -> grant goes to req0 again (alternation).
REQ-036 Req1 3-byte frame; withhold the 2nd byte past the 1st spi_next_i -> underrun_o pulses once, spi_start_o falls, remaining 2 bytes are accepted and discarded, state returns to IDLE.
REQ-037 2nd byte arrives in the exact cycle of spi_next_i -> no underrun; spi_data_o updates on that edge.
REQ-038 Single-byte frame 0xFF, CsGapCycles=4 -> spi_start_o is high until the pulse, then low for at least 4 cycles before any next frame starts.
REQ-039 rst_i asserted mid-XFER -> all outputs reach reset values next cycle; a new frame afterwards completes normally.
